// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// data width and the byte-lane mask helper.
package memory_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } memSize_e;

  // Lanes touched by an access of the given size at the given byte offset.
  function automatic logic [3:0] laneMask(input memSize_e size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << offset;
      SIZE_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// Word-organised data memory with per-byte-lane write enables and an
// asynchronous read port. Contents start at zero and are never reset.
module data_memory
  import memory_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           Clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] WordIdx,
  input  logic [3:0]                     WriteEn,
  input  logic [DATA_W-1:0]              WriteData,
  output logic [DATA_W-1:0]              ReadData
);

  logic [DATA_W-1:0] memArray_r [DEPTH_WORDS] = '{default: '0};

  // Byte-lane store into the addressed word
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (WriteEn[i]) begin
        memArray_r[WordIdx][8*i +: 8] <= WriteData[8*i +: 8];
      end
    end
  end

  assign ReadData = memArray_r[WordIdx];

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: alignment check, store lane steering, load extraction
// and the MEM/WB register, around a data_memory instance.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemRead_In,
  input  logic              MemWrite_In,
  input  logic              Branch_In,
  input  logic              RegWrite_In,
  input  logic              MemToReg_In,
  input  logic [DATA_W-1:0] ALUResult_In,
  input  logic [DATA_W-1:0] RegisterRead2_In,
  input  logic              ALUZero_In,
  input  logic [4:0]        RegDstMUX_In,
  input  logic [1:0]        MemSize_In,
  input  logic              MemSigned_In,
  input  logic              Stall,
  input  logic              Flush,
  output logic              PCSrc,
  output logic              RegWrite_reg,
  output logic              MemToReg_reg,
  output logic [DATA_W-1:0] ReadData_reg,
  output logic [DATA_W-1:0] ALUResult_reg,
  output logic [4:0]        RegDstMUX_reg,
  output logic              MisalignedErr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  memSize_e          size_s;
  logic [1:0]        offset_s;
  logic              misaligned_s;
  logic [3:0]        writeEn_s;
  logic [DATA_W-1:0] writeData_s;
  logic [DATA_W-1:0] rawWord_s;
  logic [DATA_W-1:0] shifted_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] loadData_s;

  assign size_s   = memSize_e'(MemSize_In);
  assign offset_s = ALUResult_In[1:0];
  assign PCSrc    = Branch_In & ALUZero_In;

  // Alignment check, lane enables and replicated store data
  always_comb begin
    misaligned_s = 1'b0;
    writeData_s  = RegisterRead2_In;
    case (size_s)
      SIZE_BYTE: writeData_s = {4{RegisterRead2_In[7:0]}};
      SIZE_HALF: begin
        misaligned_s = offset_s[0];
        writeData_s  = {2{RegisterRead2_In[15:0]}};
      end
      default:   misaligned_s = (offset_s != 2'b00);
    endcase
    if (!(MemRead_In || MemWrite_In)) begin
      misaligned_s = 1'b0;
    end else begin
      misaligned_s = misaligned_s;
    end
    // Stores are suppressed by any condition that stops the pipeline advancing
    if (MemWrite_In && !misaligned_s && !Stall && !Flush && !Reset) begin
      writeEn_s = laneMask(size_s, offset_s);
    end else begin
      writeEn_s = 4'b0000;
    end
  end

  data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) uDataMemory (
    .Clk       (Clk),
    .WordIdx   (ALUResult_In[AW+1:2]),
    .WriteEn   (writeEn_s),
    .WriteData (writeData_s),
    .ReadData  (rawWord_s)
  );

  assign shifted_s = rawWord_s >> {offset_s, 3'b000};
  assign half_s    = offset_s[1] ? rawWord_s[31:16] : rawWord_s[15:0];

  // Little-endian lane extraction with optional sign extension
  always_comb begin
    loadData_s = 32'h0000_0000;
    if (MemRead_In && !misaligned_s) begin
      case (size_s)
        SIZE_BYTE: loadData_s = {{24{MemSigned_In & shifted_s[7]}}, shifted_s[7:0]};
        SIZE_HALF: loadData_s = {{16{MemSigned_In & half_s[15]}}, half_s};
        default:   loadData_s = rawWord_s;
      endcase
    end else begin
      loadData_s = 32'h0000_0000;
    end
  end

  // MEM/WB register: Reset over Flush over Stall
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      RegWrite_reg  <= 1'b0;
      MemToReg_reg  <= 1'b0;
      ReadData_reg  <= 32'h0000_0000;
      ALUResult_reg <= 32'h0000_0000;
      RegDstMUX_reg <= 5'd0;
      MisalignedErr <= 1'b0;
    end else if (Stall) begin
      MisalignedErr <= 1'b0;
    end else begin
      RegWrite_reg  <= RegWrite_In & ~misaligned_s;
      MemToReg_reg  <= MemToReg_In;
      ReadData_reg  <= loadData_s;
      ALUResult_reg <= ALUResult_In;
      RegDstMUX_reg <= RegDstMUX_In;
      MisalignedErr <= misaligned_s;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised plus directed bench for memory_stage against a byte-array
// reference model of loads, stores and the MEM/WB register.
module tb_memory_stage;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        MemRead_In = 1'b0, MemWrite_In = 1'b0, Branch_In = 1'b0;
  logic        RegWrite_In = 1'b0, MemToReg_In = 1'b0, ALUZero_In = 1'b0;
  logic [31:0] ALUResult_In = 32'h0, RegisterRead2_In = 32'h0;
  logic [4:0]  RegDstMUX_In = 5'd0;
  logic [1:0]  MemSize_In = 2'b00;
  logic        MemSigned_In = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic        PCSrc, RegWrite_reg, MemToReg_reg, MisalignedErr;
  logic [31:0] ReadData_reg, ALUResult_reg;
  logic [4:0]  RegDstMUX_reg;

  int assertCount = 0;
  int failCount = 0;

  logic [7:0]  modelMem [BYTES];
  logic        eRegWrite = 1'b0, eMemToReg = 1'b0, eErr = 1'b0;
  logic [31:0] eReadData = 32'h0, eAlu = 32'h0;
  logic [4:0]  eDst = 5'd0;

  memory_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .Branch_In(Branch_In),
    .RegWrite_In(RegWrite_In), .MemToReg_In(MemToReg_In),
    .ALUResult_In(ALUResult_In), .RegisterRead2_In(RegisterRead2_In),
    .ALUZero_In(ALUZero_In), .RegDstMUX_In(RegDstMUX_In),
    .MemSize_In(MemSize_In), .MemSigned_In(MemSigned_In),
    .Stall(Stall), .Flush(Flush),
    .PCSrc(PCSrc), .RegWrite_reg(RegWrite_reg), .MemToReg_reg(MemToReg_reg),
    .ReadData_reg(ReadData_reg), .ALUResult_reg(ALUResult_reg),
    .RegDstMUX_reg(RegDstMUX_reg), .MisalignedErr(MisalignedErr)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One pipeline cycle: drive, predict from the model, clock, compare.
  task automatic step(input bit rd, input bit wr, input bit rw, input bit m2r,
                      input logic [31:0] alu, input logic [31:0] st, input logic [4:0] dst,
                      input logic [1:0] sz, input bit sgn, input bit br, input bit z,
                      input bit stall, input bit flush, input bit rst);
    int unsigned n, bidx;
    bit misal;
    logic [31:0] loadVal;
    MemRead_In = rd; MemWrite_In = wr; RegWrite_In = rw; MemToReg_In = m2r;
    ALUResult_In = alu; RegisterRead2_In = st; RegDstMUX_In = dst;
    MemSize_In = sz; MemSigned_In = sgn; Branch_In = br; ALUZero_In = z;
    Stall = stall; Flush = flush; Reset = rst;
    #1;
    checkVal("pcsrc", {31'd0, PCSrc}, {31'd0, (br && z)});

    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bidx = alu % BYTES;
    misal = (rd || wr) && ((alu % n) != 0);
    loadVal = 32'h0;
    for (int k = 0; k < int'(n); k++)
      loadVal = loadVal | (32'(modelMem[(bidx + k) % BYTES]) << (8 * k));
    if (sgn && n < 4 && loadVal[8*n-1])
      loadVal = loadVal | ~((32'h1 << (8 * n)) - 32'h1);
    if (!rd || misal) loadVal = 32'h0;

    if (rst || flush) begin
      eRegWrite = 1'b0; eMemToReg = 1'b0; eReadData = 32'h0;
      eAlu = 32'h0; eDst = 5'd0; eErr = 1'b0;
    end else if (stall) begin
      eErr = 1'b0;
    end else begin
      eRegWrite = rw && !misal; eMemToReg = m2r; eReadData = loadVal;
      eAlu = alu; eDst = dst; eErr = misal;
      if (wr && !misal)
        for (int k = 0; k < int'(n); k++)
          modelMem[(bidx + k) % BYTES] = st[8*k +: 8];
    end

    @(posedge Clk);
    #1;
    checkVal("regwrite", {31'd0, RegWrite_reg}, {31'd0, eRegWrite});
    checkVal("memtoreg", {31'd0, MemToReg_reg}, {31'd0, eMemToReg});
    checkVal("readdata", ReadData_reg, eReadData);
    checkVal("aluresult", ALUResult_reg, eAlu);
    checkVal("regdst", {27'd0, RegDstMUX_reg}, {27'd0, eDst});
    checkVal("misaligned", {31'd0, MisalignedErr}, {31'd0, eErr});
  endtask

  // Shorthands: plain store / load with pipeline running
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    step(1'b0, 1'b1, 1'b0, 1'b0, a, d, 5'd0, sz, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input bit sgn);
    step(1'b1, 1'b0, 1'b1, 1'b1, a, 32'h0, 5'd7, sz, sgn, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < BYTES; i++) modelMem[i] = 8'h00;
    #1;
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd3, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("reset_rd", ReadData_reg, 32'h0);
    checkVal("reset_rw", {31'd0, RegWrite_reg}, 32'h0);

    store(32'h10, 32'hDEADBEEF, 2'b10);
    load(32'h10, 2'b10, 1'b0);
    checkVal("ld_word", ReadData_reg, 32'hDEADBEEF);
    load(32'h13, 2'b00, 1'b1);
    checkVal("ld_byte_s", ReadData_reg, 32'hFFFFFFDE);
    load(32'h13, 2'b00, 1'b0);
    checkVal("ld_byte_u", ReadData_reg, 32'h000000DE);
    load(32'h12, 2'b01, 1'b1);
    checkVal("ld_half_s", ReadData_reg, 32'hFFFFDEAD);

    store(32'h20, 32'hCAFEF00D, 2'b10);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h21, 32'h1111, 5'd4, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkVal("misal_err", {31'd0, MisalignedErr}, 32'h1);
    checkVal("misal_rw", {31'd0, RegWrite_reg}, 32'h0);
    load(32'h20, 2'b10, 1'b0);
    checkVal("misal_err_clr", {31'd0, MisalignedErr}, 32'h0);
    checkVal("misal_nowrite", ReadData_reg, 32'hCAFEF00D);

    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55555555, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkVal("stall_hold", ReadData_reg, 32'hCAFEF00D);
    checkVal("stall_rw", {31'd0, RegWrite_reg}, 32'h1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h55555555, 5'd9, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkVal("flush_rw", {31'd0, RegWrite_reg}, 32'h0);
    load(32'h10, 2'b10, 1'b0);
    checkVal("stall_nowrite", ReadData_reg, 32'hDEADBEEF);

    store(32'h30, 32'hA5A5A5A5, 2'b10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h12345678, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkVal("rst_alu", ALUResult_reg, 32'h0);
    load(32'h30, 2'b10, 1'b0);
    checkVal("rst_nowrite", ReadData_reg, 32'hA5A5A5A5);

    store(32'h410, 32'h0BADF00D, 2'b10);
    load(32'h010, 2'b10, 1'b0);
    checkVal("wrap", ReadData_reg, 32'h0BADF00D);

    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
      step(1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
           a, $urandom(), 5'($urandom()), 2'($urandom()), 1'($urandom()),
           1'($urandom()), 1'($urandom()),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
